// File: rtl/layer_maxpool2x2_stream_if.sv
// Valid-only pixel stream bundle for the 2x2 max-pool stage.
//   data_in    : input pixel, raster order
//   valid_in   : data_in qualifier (gaps allowed)
//   data_out   : pooled pixel, holds its value while valid_out is low
//   valid_out  : one-cycle qualifier per pooled pixel
//   frame_done : pulses with the last pooled pixel of a frame
// Modports: slave = pooling stage, master = the upstream/downstream side.
interface layer_maxpool2x2_stream_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  frame_done;

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out,
        output frame_done
    );

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out,
        input  frame_done
    );
endinterface

// File: rtl/layer_maxpool2x2_stream.sv
// 2x2 stride-2 max-pool over one raster-ordered FP32 pixel stream.
// Horizontal pair maxima of even rows go to a half-width line buffer; on odd rows
// the pair maximum is combined with the buffered one and emitted one cycle later.
// Ports:
//   Clk  : clock, rising edge
//   Rst  : synchronous active-high reset
//   strm : layer_maxpool2x2_stream_if.slave (data_in/valid_in in,
//          data_out/valid_out/frame_done out)
// Build option: define MAXPOOL_RELU_EN to clamp negative pooled results
// (sign bit set, including -0 and negative NaN) to +0.
module layer_maxpool2x2_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_SIZE   = 104,
    parameter int unsigned ADDR_WIDTH = (IMG_SIZE / 2 > 1) ? $clog2(IMG_SIZE / 2) : 1
) (
    input logic                         Clk,
    input logic                         Rst,
    layer_maxpool2x2_stream_if.slave    strm
);
    localparam int unsigned HALF  = IMG_SIZE / 2;
    localparam int unsigned CNT_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam logic [CNT_W-1:0]      LAST = CNT_W'(IMG_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] SIGN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    // Maps FP bit patterns onto an unsigned total order (-0 < +0).
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x ^ SIGN);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (order_key(a) >= order_key(b)) ? a : b;
    endfunction

    logic [CNT_W-1:0]      col_q, row_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_out_q, frame_done_q;

    // Not reset: each entry is written on an even row before the odd row reads it.
    logic [DATA_WIDTH-1:0] linebuf [HALF];

    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] pair_max, pool_max, pool_out;
    logic                  last_pixel;

    always_comb begin
        idx        = ADDR_WIDTH'(col_q >> 1);
        pair_max   = fmax(hold_q, strm.data_in);
        pool_max   = fmax(linebuf[idx], pair_max);
`ifdef MAXPOOL_RELU_EN
        pool_out   = pool_max[DATA_WIDTH-1] ? '0 : pool_max;
`else
        pool_out   = pool_max;
`endif
        last_pixel = (row_q == LAST) && (col_q == LAST);
    end

    always_ff @(posedge Clk) begin
        if (!Rst && strm.valid_in && col_q[0] && !row_q[0]) begin
            linebuf[idx] <= pair_max;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (strm.valid_in) begin
                if (col_q == LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end

                if (!col_q[0]) begin
                    hold_q <= strm.data_in;
                end else if (row_q[0]) begin
                    data_out_q   <= pool_out;
                    valid_out_q  <= 1'b1;
                    frame_done_q <= last_pixel;
                end
            end
        end
    end

    assign strm.data_out   = data_out_q;
    assign strm.valid_out  = valid_out_q;
    assign strm.frame_done = frame_done_q;
endmodule

// File: tb/tb_layer_maxpool2x2_stream.sv
module tb_layer_maxpool2x2_stream;
    localparam int N4   = 4;
    localparam int NB   = 104;
    localparam int OUTB = (NB / 2) * (NB / 2);

    logic clk = 1'b0;
    logic rst4, rst104;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_maxpool2x2_stream_if #(.DATA_WIDTH(32)) if4 ();
    layer_maxpool2x2_stream_if #(.DATA_WIDTH(32)) if104 ();

    layer_maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_SIZE(N4)) dut4 (
        .Clk  (clk),
        .Rst  (rst4),
        .strm (if4)
    );

    layer_maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_SIZE(NB)) dut104 (
        .Clk  (clk),
        .Rst  (rst104),
        .strm (if104)
    );

    // Output capture, sampled on the falling edge.
    logic [31:0] q4_data[$];
    int          q4_cyc[$];
    bit          q4_fd[$];
    int          trig4[$];
    int          stray_fd4 = 0;
    logic [31:0] q104_data[$];
    bit          q104_fd[$];
    int          stray_fd104 = 0;

    always @(negedge clk) begin
        if (if4.valid_out) begin
            q4_data.push_back(if4.data_out);
            q4_cyc.push_back(cyc);
            q4_fd.push_back(if4.frame_done);
        end else if (if4.frame_done) begin
            stray_fd4++;
        end
        if (if104.valid_out) begin
            q104_data.push_back(if104.data_out);
            q104_fd.push_back(if104.frame_done);
        end else if (if104.frame_done) begin
            stray_fd104++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ordering written as sign/magnitude rules: a >= b.
    function automatic bit ref_ge(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a >= b;
        return a <= b;
    endfunction

    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
        return ref_ge(a, b) ? a : b;
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    task automatic drive4(input logic [31:0] d, input bit v);
        @(negedge clk);
        if4.data_in  = d;
        if4.valid_in = v;
    endtask

    task automatic idle4(input int n);
        for (int i = 0; i < n; i++) drive4(32'hDEADBEEF, 1'b0);
    endtask

    task automatic clear4();
        q4_data.delete();
        q4_cyc.delete();
        q4_fd.delete();
        trig4.delete();
    endtask

    task automatic frame4(input logic [31:0] px [16], input int npix, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++) drive4(32'hDEADBEEF, 1'b0);
            end
            drive4(px[i], 1'b1);
            if (((i / N4) % 2 == 1) && ((i % N4) % 2 == 1)) trig4.push_back(cyc);
        end
        idle4(3);
    endtask

    task automatic expect4(input string tag, input logic [31:0] e [4]);
        check({tag, ".count"}, q4_data.size(), 4);
        for (int k = 0; k < 4 && k < q4_data.size(); k++) begin
            check($sformatf("%s.data%0d", tag, k), q4_data[k], e[k]);
            check($sformatf("%s.lat%0d", tag, k), q4_cyc[k], trig4[k] + 1);
            check($sformatf("%s.fd%0d", tag, k), {31'b0, q4_fd[k]}, (k == 3) ? 1 : 0);
        end
        clear4();
    endtask

    logic [31:0] ramp [16];
    logic [31:0] neg [16];
    logic [31:0] sz [16];
    logic [31:0] e [4];
    logic [31:0] big [2][NB*NB];
    logic [31:0] exp104[$];

    initial begin
        if4.data_in    = '0;
        if4.valid_in   = 1'b0;
        if104.data_in  = '0;
        if104.valid_in = 1'b0;
        rst4   = 1'b1;
        rst104 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.data_out", if4.data_out, 32'h0);
        check("rst.valid_out", {31'b0, if4.valid_out}, 0);
        check("rst.frame_done", {31'b0, if4.frame_done}, 0);
        check("rst104.data_out", if104.data_out, 32'h0);
        rst4   = 1'b0;
        rst104 = 1'b0;

        ramp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                 32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

        // Ramp, continuous.
        clear4();
        frame4(ramp, 16, 1'b0);
        e = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
        expect4("ramp", e);
        check("hold.data_out", if4.data_out, 32'h41800000);

        // Negatives with a single -0.5 at (1,1).
        for (int i = 0; i < 16; i++) neg[i] = 32'hBF800000;
        neg[5] = 32'hBF000000;
        frame4(neg, 16, 1'b0);
        e = '{relu(32'hBF000000), relu(32'hBF800000), relu(32'hBF800000), relu(32'hBF800000)};
        expect4("neg", e);

        // Signed zero window: {-0, +0, -0, -0}.
        for (int i = 0; i < 16; i++) sz[i] = 32'h3F800000;
        sz[0] = 32'h80000000;
        sz[1] = 32'h00000000;
        sz[4] = 32'h80000000;
        sz[5] = 32'h80000000;
        frame4(sz, 16, 1'b0);
        e = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        expect4("szero", e);

        // Ramp with random input gaps.
        frame4(ramp, 16, 1'b1);
        e = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
        expect4("gaps", e);

        // Reset after 7 pixels; the (1,1) pair already completed, so one output precedes it.
        frame4(ramp, 7, 1'b0);
        @(negedge clk);
        rst4         = 1'b1;
        if4.valid_in = 1'b1;
        if4.data_in  = 32'h7F7FFFFF;
        @(negedge clk);
        rst4         = 1'b0;
        if4.valid_in = 1'b0;
        check("midrst.pre_count", q4_data.size(), 1);
        check("midrst.data_out", if4.data_out, 32'h0);
        clear4();
        idle4(2);
        check("midrst.quiet", q4_data.size(), 0);
        frame4(ramp, 16, 1'b0);
        e = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
        expect4("midrst", e);
        check("stray_fd4", stray_fd4, 0);

        // IMG_SIZE=104: two random frames back-to-back against the reference model.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NB * NB; i++) big[f][i] = $urandom;
            for (int r = 0; r < NB / 2; r++) begin
                for (int c = 0; c < NB / 2; c++) begin
                    exp104.push_back(ref_max(
                        ref_max(big[f][(2*r)*NB + 2*c], big[f][(2*r)*NB + 2*c + 1]),
                        ref_max(big[f][(2*r+1)*NB + 2*c], big[f][(2*r+1)*NB + 2*c + 1])));
                end
            end
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NB * NB; i++) begin
                @(negedge clk);
                if104.data_in  = big[f][i];
                if104.valid_in = 1'b1;
            end
        end
        @(negedge clk);
        if104.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check("big.count", q104_data.size(), 2 * OUTB);
        for (int k = 0; k < 2 * OUTB && k < q104_data.size(); k++) begin
            check($sformatf("big.data%0d", k), q104_data[k], relu(exp104[k]));
            check($sformatf("big.fd%0d", k), {31'b0, q104_fd[k]},
                  ((k % OUTB) == OUTB - 1) ? 1 : 0);
        end
        check("stray_fd104", stray_fd104, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
